gbuff_out_checker: RTL and testbench
====================================

GBUFF_OUT_CHECKER -- requirements
Module: gbuff_out_checker

Interface
REQ-001 Parameter LANES, default 4, meaning number of byte lanes per buffer word; power of two, 1..8.
REQ-002 Parameter LANE_W, default 8, meaning bits per lane; word width WORD_W = LANES*LANE_W.
REQ-003 Parameter ADDR_W, default 8, meaning output/golden buffer address width.
REQ-004 Parameter ERR_W, default 16, meaning error counter width.
REQ-005 Parameter TIMEOUT, default 65536, meaning maximum cycles waiting for tpu_done; must be >= 1.
REQ-006 clk  input  1  meaning sole clock; all logic on rising edge.
REQ-007 rst  input  1  meaning synchronous, active-low reset.
REQ-008 start  input  1  meaning single-cycle request to begin a check run.
REQ-009 m  input  4  meaning result rows; sampled on accepted start.
REQ-010 n  input  4  meaning result columns; sampled on accepted start.
REQ-011 lane_swap  input  1  meaning 1 = output lane j is compared with golden lane LANES-1-j; 0 = lane j with lane j; sampled on accepted start.
REQ-012 tpu_done  input  1  meaning level from TPU, high once results are in the output buffer.
REQ-013 out_rd_addr  output  ADDR_W  meaning output buffer read address.
REQ-014 out_rd_data  input  WORD_W  meaning output buffer read data, valid one cycle after the address.
REQ-015 gold_rd_addr  output  ADDR_W  meaning golden buffer read address; always equal to out_rd_addr.
REQ-016 gold_rd_data  input  WORD_W  meaning golden read data, valid one cycle after the address.
REQ-017 busy  output  1  meaning run in progress (WAIT, SWEEP, DRAIN).
REQ-018 done  output  1  meaning run complete; high in DONE.
REQ-019 pass  output  1  meaning done and err_cnt==0 and no timeout.
REQ-020 timeout  output  1  meaning tpu_done never arrived within TIMEOUT cycles.
REQ-021 err_cnt  output  ERR_W  meaning count of mismatching lanes.
REQ-022 first_err_addr  output  ADDR_W  meaning word address of first mismatch.
REQ-023 first_err_valid  output  1  meaning first_err_addr holds a captured address.

Function
REQ-024 FSM states SHALL be IDLE, WAIT, SWEEP, DRAIN and DONE.
REQ-025 IDLE or DONE with start=1 SHALL latch m, n and lane_swap, compute rows = m*ceil(n/LANES), clear err_cnt, timeout, first_err_*, and enter WAIT next cycle.
REQ-026 start SHALL be ignored in WAIT, SWEEP and DRAIN.
REQ-027 In WAIT, tpu_done=1 SHALL enter SWEEP next cycle.
REQ-028 In WAIT, a wait counter SHALL increment each cycle; if it reaches TIMEOUT-1 with tpu_done=0, timeout SHALL be set and the FSM SHALL enter SWEEP anyway.
REQ-029 If rows==0, WAIT SHALL exit to DONE instead of SWEEP, with err_cnt=0.
REQ-030 SWEEP SHALL issue addresses 0..rows-1, one per cycle, then enter DRAIN for exactly one cycle, then DONE.
REQ-031 Compare of address a SHALL occur in the cycle after a is issued, using the registered valid/address pipeline stage.
REQ-032 Per compare, err_cnt SHALL add the number of mismatching lanes (0..LANES) and saturate at all-ones.
REQ-033 On the first compare with any mismatching lane, first_err_addr SHALL capture that address and first_err_valid SHALL be set; later mismatches SHALL not update them.
REQ-034 done, pass, timeout, err_cnt and first_err_* SHALL hold in DONE until the next accepted start or reset.
REQ-035 Run latency from SWEEP entry to done=1 SHALL be rows+1 cycles.
REQ-036 Read addresses SHALL be 0 outside SWEEP.

Reset
REQ-037 rst=0 at any clock edge SHALL force IDLE and drive all outputs to 0, including mid-run; no partial results are retained.
REQ-038 After reset is released, the first start SHALL be honoured on the following clock edge.

Verification
REQ-039 Scenario: m=4, n=4, LANES=4, lane_swap=1, golden equal to byte-reversed output, tpu_done raised 10 cycles after start -> exactly one address per cycle for addresses 0..3, done 5 cycles after SWEEP entry, pass=1, err_cnt=0.
REQ-040 Scenario: m=3, n=9 (rows=9), lanes 0 and 2 corrupted at address 5, lane 1 corrupted at address 7 -> err_cnt=3, first_err_addr=5, first_err_valid=1, pass=0.
REQ-041 Scenario: TIMEOUT=16, tpu_done held 0 -> SWEEP entered 16 cycles after WAIT entry, timeout=1, pass=0 even with matching data.
REQ-042 Scenario: m=0 or n=0 -> no read addresses issued, DONE follows tpu_done by one cycle, pass=1.
REQ-043 Scenario: ERR_W=2, all lanes mismatching on 2 words -> err_cnt saturates at 3.
REQ-044 Scenario: rst=0 during SWEEP at address 2, then start again -> outputs 0 for the reset cycle, then a fresh run with err_cnt counted from 0.

Source files
------------

// File: rtl/gbuff_out_checker_if.sv
// rtl/gbuff_out_checker_if.sv - read port bundle between the checker and the output/golden buffers
interface gbuff_out_checker_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
);
    logic [ADDR_W-1:0] out_rd_addr;
    logic [WORD_W-1:0] out_rd_data;
    logic [ADDR_W-1:0] gold_rd_addr;
    logic [WORD_W-1:0] gold_rd_data;

    // Checker side issues addresses; buffer side returns data one cycle later.
    modport master (
        output out_rd_addr,
        output gold_rd_addr,
        input  out_rd_data,
        input  gold_rd_data
    );

    modport slave (
        input  out_rd_addr,
        input  gold_rd_addr,
        output out_rd_data,
        output gold_rd_data
    );
endinterface

// File: rtl/gbuff_out_checker.sv
// rtl/gbuff_out_checker.sv - compares TPU output buffer against golden buffer, lane by lane
module gbuff_out_checker #(
    parameter int LANES   = 4,
    parameter int LANE_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int ERR_W   = 16,
    parameter int TIMEOUT = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           m,
    input  logic [3:0]           n,
    input  logic                 lane_swap,
    input  logic                 tpu_done,
    gbuff_out_checker_if.master  rd,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic                 first_err_valid
);
    localparam int ROW_W  = 8;
    localparam int LSH    = $clog2(LANES);
    localparam int CNT_W  = $clog2(LANES + 1);
    localparam int SUM_W  = ERR_W + CNT_W;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   rows_q, rows_d;
    logic               lane_swap_q, lane_swap_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [ROW_W-1:0]   idx_q, idx_d;
    logic               cmp_valid_q, cmp_valid_d;
    logic [ROW_W-1:0]   cmp_addr_q, cmp_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]  first_err_addr_q, first_err_addr_d;
    logic               first_err_valid_q, first_err_valid_d;

    logic [ROW_W-1:0]   n_sum, cols, rows_new;
    logic [CNT_W-1:0]   mism_cnt;
    logic [LANE_W-1:0]  o_lane, g_lane;
    logic [SUM_W-1:0]   err_sum;
    logic [ERR_W-1:0]   err_sat;

    // rows = m * ceil(n / LANES); LANES is a power of two so the divide is a shift.
    always_comb begin
        n_sum    = ROW_W'(n) + ROW_W'(LANES - 1);
        cols     = n_sum >> LSH;
        rows_new = ROW_W'(m) * cols;
    end

    always_comb begin
        mism_cnt = '0;
        o_lane   = '0;
        g_lane   = '0;
        for (int j = 0; j < LANES; j++) begin
            o_lane = rd.out_rd_data[j*LANE_W +: LANE_W];
            g_lane = lane_swap_q ? rd.gold_rd_data[(LANES-1-j)*LANE_W +: LANE_W]
                                 : rd.gold_rd_data[j*LANE_W +: LANE_W];
            if (o_lane != g_lane) begin
                mism_cnt = mism_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        err_sum = SUM_W'(err_cnt_q) + SUM_W'(mism_cnt);
        err_sat = (err_sum > SUM_W'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    end

    always_comb begin
        state_d           = state_q;
        rows_d            = rows_q;
        lane_swap_d       = lane_swap_q;
        wait_cnt_d        = wait_cnt_q;
        idx_d             = idx_q;
        cmp_valid_d       = 1'b0;
        cmp_addr_d        = '0;
        busy_d            = busy_q;
        done_d            = done_q;
        pass_d            = pass_q;
        timeout_d         = timeout_q;
        err_cnt_d         = err_cnt_q;
        first_err_addr_d  = first_err_addr_q;
        first_err_valid_d = first_err_valid_q;

        // Compare stage: data for the address issued last cycle is on the read ports now.
        if (cmp_valid_q) begin
            err_cnt_d = err_sat;
            if ((mism_cnt != '0) && !first_err_valid_q) begin
                first_err_addr_d  = ADDR_W'(cmp_addr_q);
                first_err_valid_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d           = S_WAIT;
                    rows_d            = rows_new;
                    lane_swap_d       = lane_swap;
                    wait_cnt_d        = '0;
                    idx_d             = '0;
                    busy_d            = 1'b1;
                    done_d            = 1'b0;
                    pass_d            = 1'b0;
                    timeout_d         = 1'b0;
                    err_cnt_d         = '0;
                    first_err_addr_d  = '0;
                    first_err_valid_d = 1'b0;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (tpu_done || (wait_cnt_q == WAIT_W'(TIMEOUT - 1))) begin
                    timeout_d = !tpu_done;
                    idx_d     = '0;
                    if (rows_q == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = tpu_done;
                    end else begin
                        state_d = S_SWEEP;
                    end
                end
            end
            S_SWEEP: begin
                cmp_valid_d = 1'b1;
                cmp_addr_d  = idx_q;
                if (idx_q == rows_q - ROW_W'(1)) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ROW_W'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_cnt_d == '0) && !timeout_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= S_IDLE;
            rows_q            <= '0;
            lane_swap_q       <= 1'b0;
            wait_cnt_q        <= '0;
            idx_q             <= '0;
            cmp_valid_q       <= 1'b0;
            cmp_addr_q        <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            timeout_q         <= 1'b0;
            err_cnt_q         <= '0;
            first_err_addr_q  <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            rows_q            <= rows_d;
            lane_swap_q       <= lane_swap_d;
            wait_cnt_q        <= wait_cnt_d;
            idx_q             <= idx_d;
            cmp_valid_q       <= cmp_valid_d;
            cmp_addr_q        <= cmp_addr_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            timeout_q         <= timeout_d;
            err_cnt_q         <= err_cnt_d;
            first_err_addr_q  <= first_err_addr_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    // idx_q is held at zero outside SWEEP, so the read address needs no extra gating.
    assign rd.out_rd_addr  = ADDR_W'(idx_q);
    assign rd.gold_rd_addr = ADDR_W'(idx_q);

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_addr  = first_err_addr_q;
    assign first_err_valid = first_err_valid_q;
endmodule

// File: tb/tb_gbuff_out_checker.sv
// tb/tb_gbuff_out_checker.sv - directed self-checking bench for gbuff_out_checker
module tb_gbuff_out_checker;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  m, n;
    logic        lane_swap;
    logic        tpu_done;

    logic        busy, done, pass, timeout, first_err_valid;
    logic [15:0] err_cnt;
    logic [7:0]  first_err_addr;

    logic        busy_s, done_s, pass_s, timeout_s, first_err_valid_s;
    logic [1:0]  err_cnt_s;
    logic [7:0]  first_err_addr_s;

    logic [31:0] out_mem  [0:255];
    logic [31:0] gold_mem [0:255];

    int tests = 0;
    int fails = 0;
    int cyc;
    logic addr_seen;

    gbuff_out_checker_if #(.ADDR_W(8), .WORD_W(32)) bus ();
    gbuff_out_checker_if #(.ADDR_W(8), .WORD_W(32)) bus_s ();

    gbuff_out_checker #(.LANES(4), .LANE_W(8), .ADDR_W(8), .ERR_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .m(m), .n(n), .lane_swap(lane_swap),
        .tpu_done(tpu_done), .rd(bus), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .first_err_valid(first_err_valid)
    );

    gbuff_out_checker #(.LANES(4), .LANE_W(8), .ADDR_W(8), .ERR_W(2), .TIMEOUT(16)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .m(m), .n(n), .lane_swap(lane_swap),
        .tpu_done(tpu_done), .rd(bus_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .timeout(timeout_s), .err_cnt(err_cnt_s), .first_err_addr(first_err_addr_s),
        .first_err_valid(first_err_valid_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.out_rd_data    <= out_mem[bus.out_rd_addr];
        bus.gold_rd_data   <= gold_mem[bus.gold_rd_addr];
        bus_s.out_rd_data  <= out_mem[bus_s.out_rd_addr];
        bus_s.gold_rd_data <= gold_mem[bus_s.gold_rd_addr];
    end

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            step();
            cycles++;
        end
        check("done_within_budget", {31'b0, done}, 32'd1);
    endtask

    task automatic gold_equal();
        for (int a = 0; a < 256; a++) gold_mem[a] = out_mem[a];
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; m = '0; n = '0; lane_swap = 1'b0; tpu_done = 1'b0;
        for (int a = 0; a < 256; a++) out_mem[a] = 32'hA55A_C33C ^ (a * 32'h0103_0507);
        gold_equal();

        // reset state
        repeat (3) step();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_pass", {31'b0, pass}, 32'd0);
        check("rst_err", {16'b0, err_cnt}, 32'd0);
        check("rst_addr", {24'b0, bus.out_rd_addr}, 32'd0);
        check("rst_gaddr", {24'b0, bus.gold_rd_addr}, 32'd0);
        rst = 1'b1;

        // A: lane-swapped golden, 4 rows, tpu_done late
        for (int a = 0; a < 256; a++) gold_mem[a] = bswap(out_mem[a]);
        m = 4'd4; n = 4'd4; lane_swap = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("A_busy_wait", {31'b0, busy}, 32'd1);
        repeat (9) step();
        check("A_addr_in_wait", {24'b0, bus.out_rd_addr}, 32'd0);
        tpu_done = 1'b1;
        step();
        check("A_addr0", {24'b0, bus.out_rd_addr}, 32'd0);
        step();
        check("A_addr1", {24'b0, bus.out_rd_addr}, 32'd1);
        check("A_gaddr1", {24'b0, bus.gold_rd_addr}, 32'd1);
        step();
        check("A_addr2", {24'b0, bus.out_rd_addr}, 32'd2);
        step();
        check("A_addr3", {24'b0, bus.out_rd_addr}, 32'd3);
        step();
        check("A_drain_addr", {24'b0, bus.out_rd_addr}, 32'd0);
        check("A_drain_done", {31'b0, done}, 32'd0);
        step();
        check("A_done", {31'b0, done}, 32'd1);
        check("A_pass", {31'b0, pass}, 32'd1);
        check("A_err", {16'b0, err_cnt}, 32'd0);
        check("A_busy", {31'b0, busy}, 32'd0);
        tpu_done = 1'b0;

        // B: rows=9, three corrupted lanes across two addresses
        gold_equal();
        gold_mem[5] = gold_mem[5] ^ 32'h00FF_00FF;
        gold_mem[7] = gold_mem[7] ^ 32'h0000_FF00;
        m = 4'd3; n = 4'd9; lane_swap = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        tpu_done = 1'b1;
        step();
        wait_done(40, cyc);
        check("B_latency", cyc, 32'd10);
        check("B_err", {16'b0, err_cnt}, 32'd3);
        check("B_first_addr", {24'b0, first_err_addr}, 32'd5);
        check("B_first_valid", {31'b0, first_err_valid}, 32'd1);
        check("B_pass", {31'b0, pass}, 32'd0);
        check("B_sat_err", {30'b0, err_cnt_s}, 32'd3);
        repeat (3) step();
        check("B_hold_done", {31'b0, done}, 32'd1);
        check("B_hold_err", {16'b0, err_cnt}, 32'd3);
        tpu_done = 1'b0;

        // C: timeout with matching data; a start pulse in WAIT must be ignored
        gold_equal();
        m = 4'd2; n = 4'd4; start = 1'b1;
        step();
        start = 1'b0;
        check("C_err_cleared", {16'b0, err_cnt}, 32'd0);
        check("C_first_cleared", {31'b0, first_err_valid}, 32'd0);
        check("C_done_cleared", {31'b0, done}, 32'd0);
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 4) begin start = 1'b1; m = 4'd0; end
            if (k == 5) begin start = 1'b0; m = 4'd2; end
        end
        check("C_no_timeout_yet", {31'b0, timeout}, 32'd0);
        check("C_busy_wait", {31'b0, busy}, 32'd1);
        step();
        check("C_timeout", {31'b0, timeout}, 32'd1);
        check("C_sweep_addr0", {24'b0, bus.out_rd_addr}, 32'd0);
        step();
        check("C_sweep_addr1", {24'b0, bus.out_rd_addr}, 32'd1);
        step();
        step();
        check("C_done", {31'b0, done}, 32'd1);
        check("C_pass", {31'b0, pass}, 32'd0);
        check("C_err", {16'b0, err_cnt}, 32'd0);

        // D: m=0 then n=0, no addresses, done one cycle after tpu_done
        m = 4'd0; n = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        check("D_timeout_cleared", {31'b0, timeout}, 32'd0);
        addr_seen = 1'b0;
        repeat (3) begin
            step();
            if (bus.out_rd_addr != 8'd0) addr_seen = 1'b1;
        end
        tpu_done = 1'b1;
        step();
        if (bus.out_rd_addr != 8'd0) addr_seen = 1'b1;
        check("D_done", {31'b0, done}, 32'd1);
        check("D_pass", {31'b0, pass}, 32'd1);
        check("D_no_addr", {31'b0, addr_seen}, 32'd0);
        m = 4'd3; n = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("D_n0_done", {31'b0, done}, 32'd1);
        check("D_n0_pass", {31'b0, pass}, 32'd1);
        tpu_done = 1'b0;

        // E: every lane wrong on two words; the narrow counter saturates
        gold_mem[0] = ~out_mem[0];
        gold_mem[1] = ~out_mem[1];
        m = 4'd2; n = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        tpu_done = 1'b1;
        step();
        wait_done(20, cyc);
        check("E_latency", cyc, 32'd3);
        check("E_err", {16'b0, err_cnt}, 32'd8);
        check("E_sat_err", {30'b0, err_cnt_s}, 32'd3);
        check("E_first_addr", {24'b0, first_err_addr}, 32'd0);
        check("E_first_valid", {31'b0, first_err_valid}, 32'd1);
        check("E_sat_pass", {31'b0, pass_s}, 32'd0);

        // F: reset mid-sweep, then an immediate fresh run
        gold_equal();
        gold_mem[0] = gold_mem[0] ^ 32'h0000_00FF;
        m = 4'd4; n = 4'd4; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("F_addr2", {24'b0, bus.out_rd_addr}, 32'd2);
        check("F_err_partial", {16'b0, err_cnt}, 32'd1);
        rst = 1'b0;
        step();
        check("F_rst_busy", {31'b0, busy}, 32'd0);
        check("F_rst_err", {16'b0, err_cnt}, 32'd0);
        check("F_rst_addr", {24'b0, bus.out_rd_addr}, 32'd0);
        check("F_rst_first", {31'b0, first_err_valid}, 32'd0);
        check("F_rst_sat_err", {30'b0, err_cnt_s}, 32'd0);
        rst = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("F_restart_busy", {31'b0, busy}, 32'd1);
        step();
        wait_done(20, cyc);
        check("F_err", {16'b0, err_cnt}, 32'd1);
        check("F_first_addr", {24'b0, first_err_addr}, 32'd0);
        check("F_first_valid", {31'b0, first_err_valid}, 32'd1);
        check("F_pass", {31'b0, pass}, 32'd0);
        tpu_done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
